sd_card_dat: RTL and testbench
==============================

// Module: sd_card_dat
// PURPOSE
//  Card-side 4-bit DAT-line engine: the responder to the sd_rw host data path.
//  Transmits one 512-byte sector (start, 1024 nibbles, per-line CRC16, end) on a read.
//  Receives one sector on a write and answers with a CRC status token plus busy.
//  Sits behind a card emulator's command decoder; sector bytes come from / go to a 512x8 buffer.
// PARAMETERS
//  NAC         8        sdclk cycles between rd_start and the start bit (DAT released meanwhile)
//  BUSY_CYCLES 16       sdclk cycles DAT0 is held low after the status token
//  RX_TIMEOUT  1000000  sdclk rising edges to wait for a write start bit before giving up
// PORTS
//  clk        in   1  system clock; sdclk sampled in this domain
//  rstn       in   1  asynchronous active-low reset
//  sdclk      in   1  SD clock from host (≤ clk/4)
//  sddat_in   in   4  DAT lines as seen at the pins
//  sddat_out  out  4  DAT drive value
//  sddat_oe   out  1  1 = drive sddat_out, 0 = release (board pull-ups give 1111)
//  rd_start   in   1  1-clk pulse: send buffer contents to host
//  wr_start   in   1  1-clk pulse: expect a sector from host
//  busy       out  1  1 while any transfer is in progress
//  done       out  1  1-clk pulse at the end of a transfer
//  crc_err    out  1  last write failed CRC/end-bit check (held until next wr_start)
//  rx_timeout out  1  last write saw no start bit (held until next start)
//  buf_addr   out  9  buffer byte address
//  buf_rdata  in   8  buffer read data, valid 1 clk after buf_addr
//  buf_wdata  out  8  byte received from host
//  buf_we     out  1  1-clk write strobe for buf_wdata at buf_addr
// BEHAVIOUR
//  Reset: sddat_oe=0, sddat_out=4'hF, busy=0, done=0, crc_err=0, rx_timeout=0,
//    buf_addr=0, buf_wdata=0, buf_we=0, state=IDLE. Reset asserted mid-transfer
//    releases DAT on the same edge.
//  Edges: sdclk_l <= sdclk. rise = sdclk&~sdclk_l; fall = ~sdclk&sdclk_l.
//    Card drives/changes DAT only on fall and samples DAT only on rise.
//  Starts are accepted only in IDLE; ignored while busy. If both pulse together, rd_start wins.
//  busy rises the clk after an accepted start; done pulses with the return to IDLE.
//  CRC16 per line: poly x^16+x^12+x^5+1, init 0.
//    Next value = {c[14:0],c[15]^b} ^ {3'b0,f,6'b0,f,5'b0}, where f = c[15]^b.
//    Covers data nibbles only; sent and compared MSB first.
//  Read path (states, all transitions on fall):
//    TX_NAC: count NAC falls with oe=0.
//    TX_START: oe=1, out=0000.
//    TX_DATA: 1024 nibbles. Even index sends buf_rdata[7:4], odd index sends [3:0];
//      each nibble updates the CRCs. buf_addr=0 at start; it advances right after
//      the high nibble goes out, so the next byte is ready ≥2 clk before it is needed.
//    TX_CRC: 16 falls, line i sends crc[i][15-k].
//    TX_END: out=1111.
//    Next fall: oe=0, done. The host sees its start bit NAC+1 sdclk after rd_start.
//  Write path (sampling on rise):
//    RX_WAIT: wait for sddat_in[0]==0 (start). After RX_TIMEOUT rises set
//      rx_timeout=1 and finish (done, no token).
//    RX_DATA: 1024 nibbles, high nibble first. On each odd nibble: buf_wdata=byte,
//      buf_we pulse, buf_addr=index>>1 (0..511 in order); update CRCs.
//    RX_CRC: 16 bits per line into rcv_crc.
//    RX_END: sample end bit; require sddat_in[0]==1 (host releases, pull-up).
//      crc_err = any rcv_crc≠calc_crc OR end bit 0.
//    Token (oe=1, only out[0] meaningful, out[3:1]=1):
//      ST_GAP: 2 falls, oe=1, out=1111.
//      ST_TOKEN: 5 falls sending 0,s2,s1,s0,1 with s = 010 (ok) or 101 (crc_err).
//      ST_BUSY: out[0]=0 for BUSY_CYCLES falls.
//      ST_REL: out=1111 for 1 fall, then oe=0, done.
//    Buffer writes are not undone on CRC error.
//  Counters: 10-bit nibble index, 4-bit CRC bit index, 20-bit timeout; none wrap inside a state.
// TESTING
//  T1 buffer[i]=i, rd_start, NAC=8: start bit on the 9th fall; nibbles 0,0,0,1,...,F,F;
//     per-line CRC equals the model; end 1111; done once; oe=0 afterwards.
//  T2 host writes pattern A5,5A,... with correct CRC: 512 buf_we in address order 0..511;
//     token 0,0,1,0,1; DAT0 low 16 sdclk; crc_err=0; done once.
//  T3 as T2 with line-2 CRC bit 7 flipped: token 0,1,0,1,1; crc_err=1; all 512 bytes still written.
//  T4 wr_start with DAT held 1111, RX_TIMEOUT=100: rx_timeout=1 and done after 100 rises;
//     oe never asserted.
//  T5 rstn low at nibble 300 of a read: oe=0 and busy=0 immediately;
//     a following rd_start transmits the full sector correctly.
//  T6 rd_start and wr_start in the same clk: read performed; a wr_start during the read is ignored.

Source files
------------

// File: rtl/sd_card_dat.sv
// Card-side 4-bit SD DAT engine: sends one 512-byte sector on a read, receives one on a
// write and answers with a CRC status token followed by busy. DAT changes on sdclk fall only.
module sd_card_dat #(
    parameter int NAC         = 8,
    parameter int BUSY_CYCLES = 16,
    parameter int RX_TIMEOUT  = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sdclk,
    input  logic [3:0] sddat_in,
    output logic [3:0] sddat_out,
    output logic       sddat_oe,
    input  logic       rd_start,
    input  logic       wr_start,
    output logic       busy,
    output logic       done,
    output logic       crc_err,
    output logic       rx_timeout,
    output logic [8:0] buf_addr,
    input  logic [7:0] buf_rdata,
    output logic [7:0] buf_wdata,
    output logic       buf_we
);
    typedef enum logic [3:0] {
        IDLE, TX_NAC, TX_START, TX_DATA, TX_CRC, TX_END,
        RX_WAIT, RX_DATA, RX_CRC, RX_END,
        ST_GAP, ST_TOKEN, ST_BUSY, ST_REL, RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              sdclk_l_q;
    logic [3:0]        out_q, out_d;
    logic              oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic              crc_err_q, crc_err_d, rx_to_q, rx_to_d, we_q, we_d;
    logic [8:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [9:0]        idx_q, idx_d;
    logic [3:0]        bit_q, bit_d;
    logic [19:0]       cnt_q, cnt_d;
    logic [3:0]        half_q, half_d;
    logic [3:0][15:0]  crc_q, crc_d, rcv_q, rcv_d;

    logic       rise, fall;
    logic [3:0] nib;
    logic [4:0] tok, tok_sh;

    assign rise = sdclk & ~sdclk_l_q;
    assign fall = ~sdclk & sdclk_l_q;

    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
        logic f;
        f = c[15] ^ b;
        return {c[14:0], f} ^ {3'b0, f, 6'b0, f, 5'b0};
    endfunction

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        crc_err_d = crc_err_q;
        rx_to_d   = rx_to_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        crc_d     = crc_q;
        rcv_d     = rcv_q;
        nib       = 4'h0;
        tok       = crc_err_q ? 5'b01011 : 5'b00101;
        tok_sh    = tok << cnt_q[2:0];
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d = TX_NAC;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    addr_d  = '0;
                    rx_to_d = 1'b0;
                end else if (wr_start) begin
                    state_d   = RX_WAIT;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    crc_err_d = 1'b0;
                    rx_to_d   = 1'b0;
                end
            end
            TX_NAC: if (fall) begin
                cnt_d = cnt_q + 20'd1;
                if (cnt_q == 20'(NAC - 1)) state_d = TX_START;
            end
            TX_START: if (fall) begin
                oe_d    = 1'b1;
                out_d   = 4'h0;
                idx_d   = '0;
                crc_d   = '0;
                state_d = TX_DATA;
            end
            TX_DATA: if (fall) begin
                // Low nibble is latched so the address can move on to the next byte early.
                if (idx_q[0]) begin
                    nib = half_q;
                end else begin
                    nib    = buf_rdata[7:4];
                    half_d = buf_rdata[3:0];
                    addr_d = addr_q + 9'd1;
                end
                out_d = nib;
                for (int i = 0; i < 4; i++) crc_d[i] = crc_next(crc_q[i], nib[i]);
                idx_d = idx_q + 10'd1;
                if (idx_q == 10'd1023) begin
                    state_d = TX_CRC;
                    bit_d   = '0;
                end
            end
            TX_CRC: if (fall) begin
                for (int i = 0; i < 4; i++) out_d[i] = crc_q[i][~bit_q];
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd15) state_d = TX_END;
            end
            TX_END: if (fall) begin
                out_d   = 4'hF;
                state_d = RELEASE;
            end
            RX_WAIT: if (rise) begin
                if (!sddat_in[0]) begin
                    state_d = RX_DATA;
                    idx_d   = '0;
                    crc_d   = '0;
                end else if (cnt_q == 20'(RX_TIMEOUT - 1)) begin
                    rx_to_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            RX_DATA: if (rise) begin
                if (idx_q[0]) begin
                    wdata_d = {half_q, sddat_in};
                    we_d    = 1'b1;
                    addr_d  = idx_q[9:1];
                end else begin
                    half_d = sddat_in;
                end
                for (int i = 0; i < 4; i++) crc_d[i] = crc_next(crc_q[i], sddat_in[i]);
                idx_d = idx_q + 10'd1;
                if (idx_q == 10'd1023) begin
                    state_d = RX_CRC;
                    bit_d   = '0;
                end
            end
            RX_CRC: if (rise) begin
                for (int i = 0; i < 4; i++) rcv_d[i] = {rcv_q[i][14:0], sddat_in[i]};
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd15) state_d = RX_END;
            end
            RX_END: if (rise) begin
                crc_err_d = (rcv_q != crc_q) | ~sddat_in[0];
                cnt_d     = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: if (fall) begin
                oe_d  = 1'b1;
                out_d = 4'hF;
                cnt_d = cnt_q + 20'd1;
                if (cnt_q == 20'd1) begin
                    cnt_d   = '0;
                    state_d = ST_TOKEN;
                end
            end
            ST_TOKEN: if (fall) begin
                out_d = {3'b111, tok_sh[4]};
                cnt_d = cnt_q + 20'd1;
                if (cnt_q == 20'd4) begin
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: if (fall) begin
                out_d = 4'hE;
                cnt_d = cnt_q + 20'd1;
                if (cnt_q == 20'(BUSY_CYCLES - 1)) state_d = ST_REL;
            end
            ST_REL: if (fall) begin
                out_d   = 4'hF;
                state_d = RELEASE;
            end
            RELEASE: if (fall) begin
                oe_d    = 1'b0;
                out_d   = 4'hF;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            sdclk_l_q <= 1'b0;
            out_q     <= 4'hF;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_err_q <= 1'b0;
            rx_to_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            half_q    <= '0;
            crc_q     <= '0;
            rcv_q     <= '0;
        end else begin
            state_q   <= state_d;
            sdclk_l_q <= sdclk;
            out_q     <= out_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            crc_err_q <= crc_err_d;
            rx_to_q   <= rx_to_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            crc_q     <= crc_d;
            rcv_q     <= rcv_d;
        end
    end

    assign sddat_out  = out_q;
    assign sddat_oe   = oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign crc_err    = crc_err_q;
    assign rx_timeout = rx_to_q;
    assign buf_addr   = addr_q;
    assign buf_wdata  = wdata_q;
    assign buf_we     = we_q;
endmodule

// File: tb/tb_sd_card_dat.sv
// Bench for sd_card_dat: a host model drives sdclk/DAT, a sector buffer model serves reads
// and logs writes, and every sector/CRC/token is predicted from bit-serial CRC arithmetic.
module tb_sd_card_dat;
    localparam int NAC  = 8;
    localparam int BUSY = 16;
    localparam int RXTO = 100;

    logic       clk = 1'b0, rstn = 1'b0, sdclk = 1'b1;
    logic       rd_start = 1'b0, wr_start = 1'b0;
    logic [3:0] sddat_in, sddat_out;
    logic       sddat_oe, busy, done, crc_err, rx_timeout, buf_we;
    logic [8:0] buf_addr;
    logic [7:0] buf_rdata, buf_wdata;
    logic       host_oe = 1'b0;
    logic [3:0] host_val = 4'hF;

    int checks = 0, errors = 0;
    int done_n = 0, oe_n = 0;
    logic [8:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] rd_mem[512];
    logic [7:0] hdata[512];
    logic [3:0] nibs[1024];

    typedef struct {
        logic rnd;
        int   bad_line;
        int   bad_bit;
        logic end_ok;
        logic exp_err;
    } wvec_t;
    wvec_t tbl[5];

    assign sddat_in = sddat_oe ? sddat_out : (host_oe ? host_val : 4'hF);

    always #5 clk = ~clk;

    sd_card_dat #(.NAC(NAC), .BUSY_CYCLES(BUSY), .RX_TIMEOUT(RXTO)) dut (
        .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat_in(sddat_in),
        .sddat_out(sddat_out), .sddat_oe(sddat_oe), .rd_start(rd_start), .wr_start(wr_start),
        .busy(busy), .done(done), .crc_err(crc_err), .rx_timeout(rx_timeout),
        .buf_addr(buf_addr), .buf_rdata(buf_rdata), .buf_wdata(buf_wdata), .buf_we(buf_we)
    );

    always @(posedge clk) begin
        buf_rdata <= rd_mem[buf_addr];
        if (buf_we) begin
            wa_q.push_back(buf_addr);
            wd_q.push_back(buf_wdata);
        end
        if (done) done_n <= done_n + 1;
        if (sddat_oe) oe_n <= oe_n + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One sdclk period: low phase (card drives), sample, high phase (card samples).
    task automatic tick(output logic [3:0] o, output logic e);
        sdclk = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        o = sddat_out;
        e = sddat_oe;
        sdclk = 1'b1;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic pulse(input logic r, input logic w);
        rd_start = r;
        wr_start = w;
        @(posedge clk); #1;
        rd_start = 1'b0;
        wr_start = 1'b0;
    endtask

    // CCITT long division, one data bit at a time, over one DAT line of nibs[].
    function automatic logic [15:0] model_crc(input int line);
        logic [15:0] c;
        logic        fb;
        c = 16'h0;
        for (int i = 0; i < 1024; i++) begin
            fb = c[15] ^ nibs[i][line];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0);
        end
        return c;
    endfunction

    task automatic load_nibs(input logic is_rd);
        for (int b = 0; b < 512; b++) begin
            nibs[2*b]   = is_rd ? rd_mem[b][7:4] : hdata[b][7:4];
            nibs[2*b+1] = is_rd ? rd_mem[b][3:0] : hdata[b][3:0];
        end
    endtask

    task automatic read_check(input string tag, input int poke_tick, input logic both);
        logic [3:0]  o;
        logic        e;
        logic [15:0] ecrc[4];
        int bad_pre, bad_data, bad_crc, bad_end, bad_rel, d0, w0;
        bad_pre = 0; bad_data = 0; bad_crc = 0; bad_end = 0; bad_rel = 0;
        load_nibs(1'b1);
        for (int j = 0; j < 4; j++) ecrc[j] = model_crc(j);
        d0 = done_n;
        w0 = wa_q.size();
        pulse(1'b1, both);
        chk({tag, " busy_after_start"}, busy, 1);
        for (int t = 1; t <= NAC + 1044; t++) begin
            if (t == poke_tick) pulse(1'b0, 1'b1);
            tick(o, e);
            if (t <= NAC) begin
                if (e !== 1'b0) bad_pre++;
            end else if (t == NAC + 1) begin
                if (e !== 1'b1 || o !== 4'h0) bad_pre++;
            end else if (t <= NAC + 1025) begin
                if (e !== 1'b1 || o !== nibs[t - NAC - 2]) bad_data++;
            end else if (t <= NAC + 1041) begin
                for (int j = 0; j < 4; j++)
                    if (e !== 1'b1 || o[j] !== ecrc[j][15 - (t - NAC - 1026)]) bad_crc++;
            end else if (t == NAC + 1042) begin
                if (e !== 1'b1 || o !== 4'hF) bad_end++;
            end else begin
                if (e !== 1'b0) bad_rel++;
            end
        end
        chk({tag, " nac_and_start_bad"}, bad_pre, 0);
        chk({tag, " data_nibbles_bad"}, bad_data, 0);
        chk({tag, " crc_bits_bad"}, bad_crc, 0);
        chk({tag, " end_bit_bad"}, bad_end, 0);
        chk({tag, " release_bad"}, bad_rel, 0);
        chk({tag, " done_count"}, done_n - d0, 1);
        chk({tag, " busy_at_end"}, busy, 0);
        chk({tag, " no_buffer_writes"}, wa_q.size() - w0, 0);
    endtask

    task automatic write_check(input string tag, input wvec_t v);
        logic [3:0]  o;
        logic        e;
        logic [15:0] ecrc[4];
        logic [4:0]  tok_got, tok_exp;
        int d0, w0, bad_gap, bad_rel, bad_wr, n_busy;
        bad_gap = 0; bad_rel = 0; bad_wr = 0; n_busy = 0; tok_got = '0;
        tok_exp = v.exp_err ? 5'b01011 : 5'b00101;
        for (int b = 0; b < 512; b++)
            hdata[b] = v.rnd ? 8'($urandom) : (b[0] ? 8'h5A : 8'hA5);
        load_nibs(1'b0);
        for (int j = 0; j < 4; j++) ecrc[j] = model_crc(j);
        if (v.bad_line >= 0) ecrc[v.bad_line][v.bad_bit] = ~ecrc[v.bad_line][v.bad_bit];
        d0 = done_n;
        w0 = wa_q.size();
        pulse(1'b0, 1'b1);
        chk({tag, " busy_after_start"}, busy, 1);
        host_oe = 1'b0;
        repeat (3) tick(o, e);
        host_oe  = 1'b1;
        host_val = 4'h0;
        tick(o, e);
        for (int i = 0; i < 1024; i++) begin
            host_val = nibs[i];
            tick(o, e);
        end
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 4; j++) host_val[j] = ecrc[j][15 - k];
            tick(o, e);
        end
        host_val = v.end_ok ? 4'hF : 4'hE;
        tick(o, e);
        host_oe = 1'b0;
        for (int r = 1; r <= 26; r++) begin
            tick(o, e);
            if (r <= 2) begin
                if (e !== 1'b1 || o !== 4'hF) bad_gap++;
            end else if (r <= 7) begin
                tok_got = {tok_got[3:0], o[0]};
                if (e !== 1'b1 || o[3:1] !== 3'b111) bad_gap++;
            end else if (r <= 24) begin
                if (e === 1'b1 && o === 4'hE) n_busy++;
                if (r == 24 && (e !== 1'b1 || o !== 4'hF)) bad_rel++;
            end else begin
                if (e !== 1'b0) bad_rel++;
            end
        end
        chk({tag, " gap_bad"}, bad_gap, 0);
        chk({tag, " token"}, tok_got, tok_exp);
        chk({tag, " busy_low_sdclks"}, n_busy, BUSY);
        chk({tag, " release_bad"}, bad_rel, 0);
        chk({tag, " crc_err"}, crc_err, v.exp_err);
        chk({tag, " done_count"}, done_n - d0, 1);
        chk({tag, " write_count"}, wa_q.size() - w0, 512);
        for (int b = 0; b < 512 && w0 + b < wa_q.size(); b++)
            if (wa_q[w0 + b] !== 9'(b) || wd_q[w0 + b] !== hdata[b]) bad_wr++;
        chk({tag, " write_addr_data_bad"}, bad_wr, 0);
        chk({tag, " busy_at_end"}, busy, 0);
    endtask

    initial begin
        logic [3:0] o;
        logic       e;
        int         d0, o0;

        tbl[0] = '{rnd: 1'b0, bad_line: -1, bad_bit: 0, end_ok: 1'b1, exp_err: 1'b0};
        tbl[1] = '{rnd: 1'b0, bad_line:  2, bad_bit: 7, end_ok: 1'b1, exp_err: 1'b1};
        tbl[2] = '{rnd: 1'b1, bad_line: -1, bad_bit: 0, end_ok: 1'b1, exp_err: 1'b0};
        tbl[3] = '{rnd: 1'b1, bad_line:  0, bad_bit: 0, end_ok: 1'b1, exp_err: 1'b1};
        tbl[4] = '{rnd: 1'b1, bad_line: -1, bad_bit: 0, end_ok: 1'b0, exp_err: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset oe", sddat_oe, 0);
        chk("reset out", sddat_out, 4'hF);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset crc_err", crc_err, 0);
        chk("reset rx_timeout", rx_timeout, 0);
        chk("reset buf_addr", buf_addr, 0);
        chk("reset buf_wdata", buf_wdata, 0);
        chk("reset buf_we", buf_we, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int b = 0; b < 512; b++) rd_mem[b] = 8'(b);
        read_check("T1", 0, 1'b0);

        for (int n = 0; n < 5; n++) write_check($sformatf("W%0d", n), tbl[n]);

        d0 = done_n;
        o0 = oe_n;
        pulse(1'b0, 1'b1);
        repeat (RXTO - 1) tick(o, e);
        chk("T4 rx_timeout_early", rx_timeout, 0);
        chk("T4 done_early", done_n - d0, 0);
        tick(o, e);
        chk("T4 rx_timeout", rx_timeout, 1);
        chk("T4 done_count", done_n - d0, 1);
        chk("T4 oe_cycles", oe_n - o0, 0);
        chk("T4 busy_at_end", busy, 0);

        for (int b = 0; b < 512; b++) rd_mem[b] = 8'($urandom);
        pulse(1'b1, 1'b0);
        chk("T5 rx_timeout_cleared", rx_timeout, 0);
        repeat (NAC + 1 + 301) tick(o, e);
        chk("T5 oe_before_reset", sddat_oe, 1);
        #2 rstn = 1'b0;
        #1;
        chk("T5 oe_in_reset", sddat_oe, 0);
        chk("T5 busy_in_reset", busy, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        read_check("T5", 0, 1'b0);

        for (int b = 0; b < 512; b++) rd_mem[b] = 8'($urandom);
        read_check("T6", 50, 1'b1);
        chk("T6 rx_timeout", rx_timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
